// File: rtl/sobel_edge_3x3_if.sv
// Window/result bundle between the line-buffer window generator and the Sobel stage.
// master drives the window and threshold; slave (the detector) returns the result.
interface sobel_edge_3x3_if;
  logic       frame_start;
  logic       win_vld;
  logic [7:0] matrix_11, matrix_12, matrix_13;
  logic [7:0] matrix_21, matrix_22, matrix_23;
  logic [7:0] matrix_31, matrix_32, matrix_33;
  logic [7:0] threshold;
  logic       dout_vld;
  logic [7:0] dout;
  logic       edge_flag;

  modport master (
    output frame_start, win_vld,
    output matrix_11, matrix_12, matrix_13,
    output matrix_21, matrix_22, matrix_23,
    output matrix_31, matrix_32, matrix_33,
    output threshold,
    input  dout_vld, dout, edge_flag
  );

  modport slave (
    input  frame_start, win_vld,
    input  matrix_11, matrix_12, matrix_13,
    input  matrix_21, matrix_22, matrix_23,
    input  matrix_31, matrix_32, matrix_33,
    input  threshold,
    output dout_vld, dout, edge_flag
  );
endinterface

// File: rtl/sobel_edge_3x3.sv
// 3-stage Sobel gradient magnitude (|Gx|+|Gy|, saturated to 8 bits) with edge threshold.
// Define SOBEL_BORDER_BLANK_EN to zero windows tagged with col < 2 or row < 2.
module sobel_edge_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic            clk,
  input  logic            rst_n,
  sobel_edge_3x3_if.slave bus
);

  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [9:0] absdiff(input logic [9:0] p, input logic [9:0] n);
    return (p >= n) ? (p - n) : (n - p);
  endfunction

  logic [9:0] gx_p, gx_n, gy_p, gy_n;
  logic [9:0] ax, ay;
  logic [2:0] vld_sr;
  logic [7:0] dout_r;
  logic       edge_r;
  logic [10:0] sum;
  logic [7:0]  mag;
  logic [7:0]  mag_out;

`ifdef SOBEL_BORDER_BLANK_EN
  localparam int CW = ($clog2(IMG_W) < 2) ? 2 : $clog2(IMG_W);
  localparam int RW = ($clog2(IMG_H) < 2) ? 2 : $clog2(IMG_H);

  logic [CW-1:0] col, cur_col, col_t1, col_t2;
  logic [RW-1:0] row, cur_row, row_t1, row_t2;
  logic          blank;

  // frame_start in the same cycle as a window makes that window col 0, row 0
  always_comb begin
    cur_col = bus.frame_start ? '0 : col;
    cur_row = bus.frame_start ? '0 : row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      col_t1 <= '0;
      row_t1 <= '0;
      col_t2 <= '0;
      row_t2 <= '0;
    end else begin
      if (bus.win_vld) begin
        if (cur_col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end else if (bus.frame_start) begin
        col <= '0;
        row <= '0;
      end
      col_t1 <= cur_col;
      row_t1 <= cur_row;
      col_t2 <= col_t1;
      row_t2 <= row_t1;
    end
  end

  assign blank = (col_t2 < CW'(2)) || (row_t2 < RW'(2));
`endif

  always_comb begin
    sum = {1'b0, ax} + {1'b0, ay};
    mag = (sum > 11'd255) ? 8'hFF : sum[7:0];
`ifdef SOBEL_BORDER_BLANK_EN
    mag_out = blank ? '0 : mag;
`else
    mag_out = mag;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p   <= '0;
      gx_n   <= '0;
      gy_p   <= '0;
      gy_n   <= '0;
      ax     <= '0;
      ay     <= '0;
      vld_sr <= '0;
      dout_r <= '0;
      edge_r <= 1'b0;
    end else begin
      gx_p   <= wsum(bus.matrix_13, bus.matrix_23, bus.matrix_33);
      gx_n   <= wsum(bus.matrix_11, bus.matrix_21, bus.matrix_31);
      gy_p   <= wsum(bus.matrix_31, bus.matrix_32, bus.matrix_33);
      gy_n   <= wsum(bus.matrix_11, bus.matrix_12, bus.matrix_13);
      ax     <= absdiff(gx_p, gx_n);
      ay     <= absdiff(gy_p, gy_n);
      vld_sr <= {vld_sr[1:0], bus.win_vld};
      dout_r <= mag_out;
      edge_r <= (mag_out > bus.threshold);
    end
  end

  assign bus.dout_vld  = vld_sr[2];
  assign bus.dout      = dout_r;
  assign bus.edge_flag = edge_r;

endmodule

// File: doc/sobel_edge_3x3.md
# sobel_edge_3x3

Pipelined Sobel edge detector that consumes the nine 8-bit pixels of a 3x3 window produced by the line-buffer window generator and emits one gradient-magnitude pixel plus a binary edge flag per valid window. It sits directly downstream of the window generator in the image-process chain, between the grayscale stage and the display/SDRAM write path. Latency is fixed at 3 clocks, with one result per clock and no back-pressure.

## Interface
- IMG_W, 640, pixels per line (column counter wrap, border logic)
- IMG_H, 480, lines per frame (row counter wrap, border logic)
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  single-cycle pulse before the first window of a frame; clears row/column counters
- win_vld  in  1  window valid, aligned with the matrix inputs (the window generator's din_vld delayed by one clock)
- matrix_11..matrix_33  in  8 each  window pixels; first digit is row (1 = oldest line), second digit is column (1 = oldest pixel)
- threshold  in  8  edge threshold; sampled in stage 3
- dout_vld  out  1  win_vld delayed by 3 clocks
- dout  out  8  saturated gradient magnitude
- edge_flag  out  1  1 when dout > threshold

## Operation
- Stage 1 (registered): compute Gx_p = m13 + 2·m23 + m33, Gx_n = m11 + 2·m21 + m31, Gy_p = m31 + 2·m32 + m33, Gy_n = m11 + 2·m12 + m13. All are unsigned 10-bit values (max 1020).
- Stage 2 (registered): ax = |Gx_p − Gx_n| and ay = |Gy_p − Gy_n|, each 10-bit unsigned. Compute the larger operand minus the smaller; no signed arithmetic.
- Stage 3 (registered): s = ax + ay (11-bit, max 2040). dout = (s > 255) ? 255 : s[7:0]. edge_flag = (dout > threshold), a strict comparison.
- Valid pipeline: a 3-bit shift register of win_vld. Data registers may update on every clock. Only dout_vld qualifies dout and edge_flag.
- Counters: col (0..IMG_W−1) increments on each win_vld and wraps to 0. When col wraps, row (0..IMG_H−1) increments, and row wraps to 0 after IMG_H−1. frame_start forces col = row = 0. If frame_start and win_vld occur in the same cycle, that window is counted as col 0, row 0, and the counters then hold col 1, row 0.
- Counter values are tagged onto each window at stage 1 and carried alongside the data so the border decision stays aligned with it.

## Timing
- A window presented on win_vld at clock edge N produces dout, edge_flag and dout_vld = 1 after edge N+3.
- Gaps in win_vld (horizontal blanking) propagate unchanged, so dout_vld has the same pattern as win_vld shifted by 3 clocks.
- Reset values: dout = 0, edge_flag = 0, dout_vld = 0, all pipeline registers = 0, col = row = 0.
- Reset asserted mid-frame clears everything asynchronously. The first window after reset release is counted as col 0, row 0 even without a frame_start pulse.
- A change to threshold takes effect on the window that is in stage 3 at that edge. No synchronisation is applied.

## Configuration
- SOBEL_BORDER_BLANK_EN defined:
  - Windows tagged with col < 2 or row < 2 are invalid, because they straddle a line wrap or the top of the frame.
  - For those windows, dout = 0 and edge_flag = 0, while dout_vld still asserts.
- SOBEL_BORDER_BLANK_EN undefined:
  - The counters and tags are not synthesised.
  - Every window is processed as-is.

## Test plan
- All nine pixels = 100, threshold = 10 → dout = 0, edge_flag = 0, dout_vld 3 clocks after win_vld.
- Vertical edge: column 1 = 0, columns 2 and 3 = 255, threshold = 128 → Gx = 1020, Gy = 0, dout = 255 (saturated), edge_flag = 1.
- Weak horizontal gradient: row 1 = 10, row 2 = 10, row 3 = 20, threshold = 40 → Gy = 40, dout = 40, edge_flag = 0. Repeat with threshold = 39 → edge_flag = 1.
- Burst of 5 windows, a 2-cycle gap, then 3 windows → dout_vld reproduces the 5-on/2-off/3-on pattern with a 3-clock delay, and the data is in order.
- With SOBEL_BORDER_BLANK_EN, IMG_W = 8, IMG_H = 4, and the vertical-edge window fed for a full frame → outputs at col 0/1 or row 0/1 are dout = 0; all others are 255. A frame_start pulse restarts the blanking.
- Assert rst_n low while 2 windows are in flight → dout_vld drops to 0 immediately, no stale output appears after release, and the counters restart at 0.
